regfile_wport_arbiter: RTL and testbench
========================================

# regfile_wport_arbiter

Shares the single write port of the 2-read/1-write register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is memory/load writeback. Each requester has a one-entry holding register. A round-robin arbiter drains the holding registers into a registered write stage that drives the register file's write address, write data and write enable. The block also flags read-after-write hazards on the two read addresses, so the CPU sequencer can stall until pending writes have landed.

## Interface
Parameters:
- ADDR_SIZE, 5, register address width
- DATA_SIZE, 32, register data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a write to deliver
- req0_ready  out  1  requester 0 write accepted this cycle if valid
- req0_addr  in  ADDR_SIZE  requester 0 destination register
- req0_data  in  DATA_SIZE  requester 0 write data
- req1_valid / req1_ready / req1_addr / req1_data  same widths and meanings as requester 0, for requester 1
- wa  out  ADDR_SIZE  register file write address (registered)
- wdata  out  DATA_SIZE  register file write data (registered)
- wen  out  1  register file write enable (registered)
- ra  in  ADDR_SIZE  read port A address, for hazard check
- rb  in  ADDR_SIZE  read port B address, for hazard check
- ra_busy  out  1  a write to ra is still pending (combinational)
- rb_busy  out  1  a write to rb is still pending (combinational)
- idle  out  1  no holding entry is valid and wen=0

## Operation
- **State:**
  - hold_valid[1:0], with hold_addr and hold_data per requester
  - rr_ptr, 1 bit: the requester favoured on the next tie
  - output registers wa, wdata, wen
- **Handshake:**
  - reqN_ready = !hold_valid[N] | grant[N]
  - Acceptance happens when valid and ready are both high; the holding register loads at the edge.
  - Valid may drop without acceptance; the block imposes no stability requirement.
- **Grant:**
  - One holding entry is granted per cycle.
  - If only one entry is valid, it is granted.
  - If both are valid, requester rr_ptr is granted.
  - After any grant, rr_ptr is set to the non-granted requester.
  - With no grant, rr_ptr is unchanged.
- **Write stage:**
  - On a grant, at the edge: wa←hold_addr, wdata←hold_data, and wen←(hold_addr≠0).
  - Without a grant, wen←0, and wa/wdata hold their values.
- **Register 0:**
  - A write to register 0 is accepted and arbitrated normally.
  - It never asserts wen and never sets busy.
- **Simultaneous events:** a granted entry may be refilled from the same requester in the same cycle. The new data wins, and the hold stays valid.
- **Hazards:**
  - raBusy/rbBusy rule: ra_busy = (ra≠0) & ((hold_valid[0]&hold_addr0==ra) | (hold_valid[1]&hold_addr1==ra) | (wen&wa==ra)); rb_busy is the same with rb.
- **Ordering:**
  - Within one requester, writes reach the register file in acceptance order.
  - Across requesters, order is the arbitration order. The sequencer is responsible for avoiding same-register collisions, using the busy flags.
- **Reset (asynchronous, any time):**
  - hold_valid=0, rr_ptr=0, wen=0, wa=0, wdata=0.
  - In-flight writes are discarded.
  - Consequently reqN_ready=1, busy=0 and idle=1.

## Timing
- A handshake in cycle k sets the hold valid in cycle k+1.
- The earliest grant is in k+1, which gives wen=1 in k+2.
- The register file captures the write at the end of k+2, so the value is readable from k+3.
- Best-case latency is 2 cycles from acceptance to wen.
- Under contention the worst case is 3 cycles: one lost arbitration.
- Sustained throughput is one write per cycle total, and each requester gets at least one write every 2 cycles.
- The busy flags cover every cycle from k+1 through k+2 inclusive.

## Structure
- Shared package holds:
  - ADDR_SIZE and DATA_SIZE defaults
  - the REG_ZERO constant
  - a writeback request typedef {valid, addr, data}
- A natural sub-module is `rr_arb2`: a 2-way round-robin arbiter with request[1:0] in, grant[1:0] out, and an internal pointer with asynchronous reset.
- Holding registers, the write stage and the hazard compare live in the top level.

## Test plan
- **Reset mid-operation:** assert rst asynchronously while both holds are valid and wen=1.
  - Immediately: wen=0, both readies=1, idle=1.
  - No write reaches the register file afterwards.
- **Single write:** req0 writes addr 5, data 0xDEADBEEF in cycle 0.
  - Cycle 2: wen=1, wa=5, wdata=0xDEADBEEF.
  - ra_busy=1 for ra=5 in cycles 1–2, and 0 in cycle 3.
- **Contention:** both requesters valid in every cycle from reset (req0 addr 1, req1 addr 2).
  - wen pattern is continuous.
  - wa sequence is 1,2,1,2…
  - Each ready is high every other cycle.
- **Register 0:** req1 writes addr 0, data 0x1234.
  - It is accepted, and wen stays 0.
  - ra_busy=0 for ra=0.
  - idle returns to 1 after 2 cycles.
- **Back-to-back refill:** req0 is valid continuously with addr 3,4,5 and req1 is idle.
  - One acceptance per cycle.
  - wen=1 on three consecutive cycles, with wa=3,4,5 in order.
- **Busy on output stage only:** with rb=7, accept a write to 7 and then stop requests.
  - rb_busy is high exactly while the hold is valid or wen&wa=7.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// regfile_wport_arbiter_pkg: shared widths, register-zero constant and writeback request type
package regfile_wport_arbiter_pkg;
  localparam int DEF_ADDR_SIZE = 5;
  localparam int DEF_DATA_SIZE = 32;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic valid;
    logic [DEF_ADDR_SIZE-1:0] addr;
    logic [DEF_DATA_SIZE-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: writeback requests, register file write port and hazard flags
interface regfile_wport_arbiter_if
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_SIZE-1:0] req0_addr, req1_addr, wa, ra, rb;
  logic [DATA_SIZE-1:0] req0_data, req1_data, wdata;
  logic wen, ra_busy, rb_busy, idle;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, ra, rb,
    input req0_ready, req1_ready, wa, wdata, wen, ra_busy, rb_busy, idle
  );
  modport slave (
    input req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, ra, rb,
    output req0_ready, req1_ready, wa, wdata, wen, ra_busy, rb_busy, idle
  );
endinterface

// File: rtl/regfile_wport_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter favouring the loser of the last grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt = (req == 2'b11) ? (ptr_q ? 2'b10 : 2'b01) : req;
    ptr_d = |gnt ? gnt[0] : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register file write port between ALU and load writeback
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input logic clk,
  input logic rst,
  regfile_wport_arbiter_if.slave bus
);
  localparam logic [ADDR_SIZE-1:0] ZERO = ADDR_SIZE'(REG_ZERO);
  logic [1:0] hold_valid_q, hold_valid_d, gnt, acc, in_valid;
  logic [ADDR_SIZE-1:0] hold_addr_q [2], hold_addr_d [2], in_addr [2];
  logic [DATA_SIZE-1:0] hold_data_q [2], hold_data_d [2], in_data [2];
  logic [ADDR_SIZE-1:0] wa_q, wa_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic wen_q, wen_d, sel;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(hold_valid_q), .gnt(gnt));
  always_comb begin
    in_valid = {bus.req1_valid, bus.req0_valid};
    in_addr[0] = bus.req0_addr;
    in_addr[1] = bus.req1_addr;
    in_data[0] = bus.req0_data;
    in_data[1] = bus.req1_data;
    acc = in_valid & (~hold_valid_q | gnt);
    for (int i = 0; i < 2; i++) begin
      hold_valid_d[i] = acc[i] | (hold_valid_q[i] & ~gnt[i]);
      hold_addr_d[i] = acc[i] ? in_addr[i] : hold_addr_q[i];
      hold_data_d[i] = acc[i] ? in_data[i] : hold_data_q[i];
    end
    sel = gnt[1];
    wa_d = |gnt ? hold_addr_q[sel] : wa_q;
    wdata_d = |gnt ? hold_data_q[sel] : wdata_q;
    wen_d = |gnt & (hold_addr_q[sel] != ZERO);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_addr_q <= '{default: '0};
      hold_data_q <= '{default: '0};
      wa_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      wa_q <= wa_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
    end
  end
  always_comb begin
    bus.req0_ready = ~hold_valid_q[0] | gnt[0];
    bus.req1_ready = ~hold_valid_q[1] | gnt[1];
    bus.wa = wa_q;
    bus.wdata = wdata_q;
    bus.wen = wen_q;
    bus.idle = ~|hold_valid_q & ~wen_q;
    bus.ra_busy = (bus.ra != ZERO) & ((hold_valid_q[0] & (hold_addr_q[0] == bus.ra)) |
                  (hold_valid_q[1] & (hold_addr_q[1] == bus.ra)) | (wen_q & (wa_q == bus.ra)));
    bus.rb_busy = (bus.rb != ZERO) & ((hold_valid_q[0] & (hold_addr_q[0] == bus.rb)) |
                  (hold_valid_q[1] & (hold_addr_q[1] == bus.rb)) | (wen_q & (wa_q == bus.rb)));
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed and random checks against a behavioural write-port model
module tb_regfile_wport_arbiter;
  import regfile_wport_arbiter_pkg::*;
  logic clk = 0, rst = 1;
  int total = 0, passed = 0;
  wb_req_t hold [2];
  bit fav, m_wen;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  regfile_wport_arbiter_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) bus ();
  regfile_wport_arbiter #(.ADDR_SIZE(5), .DATA_SIZE(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic bit busy_m(input logic [4:0] a);
    return a != 0 && ((hold[0].valid && hold[0].addr == a) ||
                      (hold[1].valid && hold[1].addr == a) || (m_wen && m_wa == a));
  endfunction
  task automatic model_reset();
    hold[0] = '0;
    hold[1] = '0;
    fav = 0;
    m_wen = 0;
    m_wa = 0;
    m_wd = 0;
  endtask
  task automatic drive_idle();
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
    bus.ra = 0; bus.rb = 0;
  endtask
  task automatic do_reset();
    drive_idle();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] ra, input logic [4:0] rb);
    int g;
    bit r0, r1;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.ra = ra; bus.rb = rb;
    #1;
    g = (hold[0].valid && hold[1].valid) ? int'(fav) : hold[0].valid ? 0 : hold[1].valid ? 1 : -1;
    r0 = !hold[0].valid || g == 0;
    r1 = !hold[1].valid || g == 1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(r1));
    chk("wen", 32'(bus.wen), 32'(m_wen));
    chk("wa", 32'(bus.wa), 32'(m_wa));
    chk("wdata", bus.wdata, m_wd);
    chk("ra_busy", 32'(bus.ra_busy), 32'(busy_m(ra)));
    chk("rb_busy", 32'(bus.rb_busy), 32'(busy_m(rb)));
    chk("idle", 32'(bus.idle), 32'(!hold[0].valid && !hold[1].valid && !m_wen));
    if (g >= 0) begin
      m_wa = hold[g].addr;
      m_wd = hold[g].data;
      m_wen = hold[g].addr != 0;
      fav = (g == 0);
      hold[g].valid = 0;
    end else m_wen = 0;
    if (v0 && r0) hold[0] = '{1'b1, a0, d0};
    if (v1 && r1) hold[1] = '{1'b1, a1, d1};
  endtask
  initial begin
    drive_idle();
    model_reset();
    #1;
    chk("reset_wen", 32'(bus.wen), 0);
    chk("reset_idle", 32'(bus.idle), 1);
    do_reset();
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_busy_c1", 32'(bus.ra_busy), 1);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_wen_c2", 32'(bus.wen), 1);
    chk("single_wa_c2", 32'(bus.wa), 5);
    chk("single_wdata_c2", bus.wdata, 32'hDEADBEEF);
    chk("single_busy_c2", 32'(bus.ra_busy), 1);
    cycle(0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_busy_c3", 32'(bus.ra_busy), 0);
    do_reset();
    for (int j = 0; j < 10; j++) begin
      cycle(1, 1, 32'(100 + j), 1, 2, 32'(200 + j), 1, 2);
      if (j >= 1) chk("cont_ready_alt", 32'(bus.req0_ready ^ bus.req1_ready), 1);
      if (j >= 2) begin
        chk("cont_wen", 32'(bus.wen), 1);
        chk("cont_wa", 32'(bus.wa), (j % 2 == 0) ? 1 : 2);
      end
    end
    #2 rst = 1;
    #1;
    chk("async_rst_wen", 32'(bus.wen), 0);
    chk("async_rst_ready0", 32'(bus.req0_ready), 1);
    chk("async_rst_ready1", 32'(bus.req1_ready), 1);
    chk("async_rst_idle", 32'(bus.idle), 1);
    do_reset();
    for (int j = 0; j < 4; j++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, 2);
      chk("post_rst_no_wen", 32'(bus.wen), 0);
    end
    do_reset();
    cycle(0, 0, 0, 1, 0, 32'h1234, 0, 0);
    chk("r0_accept", 32'(bus.req1_ready), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_busy", 32'(bus.ra_busy), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_wen", 32'(bus.wen), 0);
    chk("r0_idle", 32'(bus.idle), 1);
    do_reset();
    for (int j = 0; j < 6; j++) begin
      cycle(j < 3, 5'(3 + j), 32'(j), 0, 0, 0, 0, 0);
      if (j < 3) chk("b2b_ready", 32'(bus.req0_ready), 1);
      if (j >= 2 && j < 5) begin
        chk("b2b_wen", 32'(bus.wen), 1);
        chk("b2b_wa", 32'(bus.wa), 32'(3 + j - 2));
      end
    end
    do_reset();
    cycle(1, 7, 32'h77, 0, 0, 0, 0, 7);
    chk("rb_busy_c0", 32'(bus.rb_busy), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 7);
    chk("rb_busy_hold", 32'(bus.rb_busy), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 7);
    chk("rb_busy_wen", 32'(bus.rb_busy), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 7);
    chk("rb_busy_done", 32'(bus.rb_busy), 0);
    do_reset();
    for (int j = 0; j < 400; j++)
      cycle($urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
            $urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
            5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
